// File: rtl/mod_n_updown_chain.sv
// Cascade of DIGITS mod-N up/down digit counters with parallel load, terminal count and wrap pulse.
// Optional build macro MOD_N_UPDOWN_CHAIN_SATURATE_EN: hold at the terminal state instead of wrapping.
module mod_n_updown_chain #(
  parameter int DW      = 4,
  parameter int N       = 10,
  parameter int DIGITS  = 2,
  parameter int RST_MAX = 1
) (
  input  logic                   clk_50MHz_i,
  input  logic                   rst_sync_ha_i,
  input  logic                   enable_i,
  input  logic                   up_i,
  input  logic                   load_i,
  input  logic [DIGITS*DW-1:0]   load_val_i,
  output logic [DIGITS*DW-1:0]   count_o,
  output logic                   tc_o,
  output logic                   wrapped_o
);

  localparam logic [DW-1:0]        MAXV    = DW'(N - 1);
  localparam logic [DIGITS*DW-1:0] RST_VAL = (RST_MAX != 0) ? {DIGITS{MAXV}} : '0;

  logic [DIGITS*DW-1:0] count_nxt;
  logic [DIGITS*DW-1:0] load_clamped;
  // step[k] means digit k moves this cycle; step[DIGITS] means every digit is at its terminal value.
  logic [DIGITS:0]      step;

  always_comb begin
    count_nxt    = count_o;
    load_clamped = '0;
    step         = '0;
    step[0]      = enable_i;
    for (int k = 0; k < DIGITS; k++) begin
      if (step[k]) begin
        if (up_i)
          count_nxt[k*DW +: DW] = (count_o[k*DW +: DW] == MAXV) ? '0 : count_o[k*DW +: DW] + 1'b1;
        else
          count_nxt[k*DW +: DW] = (count_o[k*DW +: DW] == '0) ? MAXV : count_o[k*DW +: DW] - 1'b1;
      end
      step[k+1] = step[k] & (up_i ? (count_o[k*DW +: DW] == MAXV) : (count_o[k*DW +: DW] == '0));
      load_clamped[k*DW +: DW] = (load_val_i[k*DW +: DW] > MAXV) ? MAXV : load_val_i[k*DW +: DW];
    end
  end

  assign tc_o = step[DIGITS];

  always_ff @(posedge clk_50MHz_i) begin
    if (rst_sync_ha_i) begin
      count_o   <= RST_VAL;
      wrapped_o <= 1'b0;
    end else if (load_i) begin
      count_o   <= load_clamped;
      wrapped_o <= 1'b0;
    end else begin
`ifdef MOD_N_UPDOWN_CHAIN_SATURATE_EN
      if (!tc_o)
        count_o <= count_nxt;
      wrapped_o <= 1'b0;
`else
      count_o   <= count_nxt;
      wrapped_o <= tc_o;
`endif
    end
  end

endmodule
